t2mi_frame_scheduler: RTL and testbench

//  Sequences T2-MI packet generation per T2 frame: plp_num_blocks BB-frame packets, then one
//  T2 timestamp packet, then one L1-current packet; repeats for num_t2_frames per superframe.

---
 rtl/t2mi_frame_scheduler_pkg.sv | 39 +++
 rtl/t2mi_frame_scheduler_watchdog.sv | 36 +++
 rtl/t2mi_frame_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_t2mi_frame_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t2mi_frame_scheduler_pkg.sv
// Shared definitions for the T2-MI frame scheduler.
// Holds the T2-MI packet_type codes, the scheduler FSM state encoding, the
// default PKT_DONE timeout, and a helper that maps a state to the packet type
// that state requests.
package t2mi_frame_scheduler_pkg;

  localparam logic [7:0] PT_BB    = 8'h00;
  localparam logic [7:0] PT_L1CUR = 8'h10;
  localparam logic [7:0] PT_TS    = 8'h20;

  localparam int DONE_TMO_DEF = 4096;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FRM_BEGIN = 4'd1,
    ST_BB_WAIT   = 4'd2,
    ST_BB_REQ    = 4'd3,
    ST_BB_DONE   = 4'd4,
    ST_TS_REQ    = 4'd5,
    ST_TS_DONE   = 4'd6,
    ST_L1_REQ    = 4'd7,
    ST_L1_DONE   = 4'd8,
    ST_FRM_END   = 4'd9
  } state_e;

  // Packet type belonging to a REQ/DONE state; 0 elsewhere.
  function automatic logic [7:0] state_pkt_type(input state_e s);
    logic [7:0] t;
    t = 8'h00;
    case (s)
      ST_BB_REQ, ST_BB_DONE: t = PT_BB;
      ST_TS_REQ, ST_TS_DONE: t = PT_TS;
      ST_L1_REQ, ST_L1_DONE: t = PT_L1CUR;
      default:               t = 8'h00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/t2mi_frame_scheduler_watchdog.sv
// t2mi_sched_watchdog: counts cycles spent waiting for PKT_DONE.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart count at 0 (request transfer)
//   run       - count while high (scheduler waiting in a DONE state)
//   expire    - high while running with the count at DONE_TMO-1
module t2mi_sched_watchdog #(
  parameter int DONE_TMO = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(DONE_TMO) + 1;
  localparam logic [CW-1:0] LAST = CW'(DONE_TMO - 1);
  localparam logic [CW-1:0] ONE  = 1;

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == LAST);

  // Saturates at LAST; the scheduler leaves the DONE state on expiry anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expire) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/t2mi_frame_scheduler.sv
// t2mi_frame_scheduler: per T2 frame, requests plp_num_blocks BB-frame
// packets, then one timestamp packet, then one L1-current packet, and repeats
// for num_t2_frames frames per superframe. Block/frame counts are latched at
// the start of each superframe.
// Ports:
//   CLK, RST            - byte clock, asynchronous active-high reset
//   START, ENA          - scheduling allowed (level), output-side enable
//   BB_AVAIL            - a full BB frame is buffered upstream
//   plp_num_blocks      - BB frames per T2 frame
//   num_t2_frames       - T2 frames per superframe (0 behaves as 1)
//   REQ_VALID/TYPE/READY, PKT_DONE - request handshake to the packet builder
//   FRAME_IDX, SF_IDX, BB_IDX      - current position in the schedule
//   FRAME_START         - pulse at the start of every T2 frame
//   ERR_TMO             - sticky: PKT_DONE did not arrive within DONE_TMO
//   STAT_BB_CNT/FRM_CNT - statistics, only with T2MI_SCHED_STATS_EN defined
//   fsm_state           - current FSM state for debug/observation
//
// Handshake: REQ_VALID is high in a *_REQ state while ENA is high, REQ_TYPE
// is held for the whole state; a transfer is a cycle with REQ_VALID and
// REQ_READY both high, after which the FSM waits in *_DONE for a PKT_DONE
// pulse. Dropping ENA before the transfer withdraws REQ_VALID only.
module t2mi_frame_scheduler
  import t2mi_frame_scheduler_pkg::*;
#(
  parameter int NB_W     = 10,
  parameter int NF_W     = 8,
  parameter int SF_W     = 4,
  parameter int DONE_TMO = DONE_TMO_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            ENA,
  input  logic            BB_AVAIL,
  input  logic [NB_W-1:0] plp_num_blocks,
  input  logic [NF_W-1:0] num_t2_frames,
  output logic            REQ_VALID,
  output logic [7:0]      REQ_TYPE,
  input  logic            REQ_READY,
  input  logic            PKT_DONE,
  output logic [NF_W-1:0] FRAME_IDX,
  output logic [SF_W-1:0] SF_IDX,
  output logic [NB_W-1:0] BB_IDX,
  output logic            FRAME_START,
  output logic            ERR_TMO,
  output logic [31:0]     STAT_BB_CNT,
  output logic [31:0]     STAT_FRM_CNT,
  output state_e          fsm_state
);

  localparam logic [NB_W-1:0] NB_ONE = 1;
  localparam logic [NF_W-1:0] NF_ONE = 1;
  localparam logic [SF_W-1:0] SF_ONE = 1;

  state_e          state, state_n;
  logic [NF_W-1:0] frame_idx;
  logic [SF_W-1:0] sf_idx;
  logic [NB_W-1:0] bb_idx;
  logic [NB_W-1:0] lat_blocks;
  logic [NF_W-1:0] lat_frames;
  logic            err_tmo;
  logic            start_q;

  logic            is_req, is_done, req_valid, xfer, wd_expire, tmo_hit;
  logic            start_rise, clr_idx, last_bb, last_frm;
  logic [NB_W-1:0] blocks_eff;
  logic [NF_W-1:0] frames_eff;

  assign is_req     = (state == ST_BB_REQ) || (state == ST_TS_REQ) || (state == ST_L1_REQ);
  assign is_done    = (state == ST_BB_DONE) || (state == ST_TS_DONE) || (state == ST_L1_DONE);
  assign req_valid  = is_req && ENA;
  assign xfer       = req_valid && REQ_READY;
  assign start_rise = START && !start_q;
  // A PKT_DONE arriving in the expiry cycle still completes the packet.
  assign tmo_hit    = wd_expire && !PKT_DONE;
  // At frame 0 the block count is being latched this cycle, so decide on the input.
  assign blocks_eff = (frame_idx == '0) ? plp_num_blocks : lat_blocks;
  assign frames_eff = (lat_frames == '0) ? NF_ONE : lat_frames;
  assign last_bb    = (bb_idx == lat_blocks - NB_ONE);
  assign last_frm   = (frame_idx == frames_eff - NF_ONE);

  t2mi_sched_watchdog #(.DONE_TMO(DONE_TMO)) u_wd (
    .clk    (CLK),
    .rst    (RST),
    .clear  (xfer),
    .run    (is_done),
    .expire (wd_expire)
  );

  always_comb begin
    state_n = state;
    clr_idx = 1'b0;
    case (state)
      // After a timeout, a fresh START edge is needed to resume.
      ST_IDLE:      if (START && (!err_tmo || start_rise)) state_n = ST_FRM_BEGIN;
      ST_FRM_BEGIN: begin
        if (!START) begin
          state_n = ST_IDLE;
          clr_idx = 1'b1;
        end else if (blocks_eff == '0) begin
          state_n = ST_TS_REQ;
        end else begin
          state_n = ST_BB_WAIT;
        end
      end
      ST_BB_WAIT: begin
        if (!START) begin
          state_n = ST_IDLE;
          clr_idx = 1'b1;
        end else if (BB_AVAIL && ENA) begin
          state_n = ST_BB_REQ;
        end
      end
      ST_BB_REQ: if (xfer) state_n = ST_BB_DONE;
      ST_BB_DONE: begin
        if (PKT_DONE) begin
          if (!START) begin
            state_n = ST_IDLE;
            clr_idx = 1'b1;
          end else begin
            state_n = last_bb ? ST_TS_REQ : ST_BB_WAIT;
          end
        end else if (tmo_hit) begin
          state_n = ST_IDLE;
          clr_idx = 1'b1;
        end
      end
      ST_TS_REQ: if (xfer) state_n = ST_TS_DONE;
      ST_TS_DONE: begin
        if (PKT_DONE) begin
          if (!START) begin
            state_n = ST_IDLE;
            clr_idx = 1'b1;
          end else begin
            state_n = ST_L1_REQ;
          end
        end else if (tmo_hit) begin
          state_n = ST_IDLE;
          clr_idx = 1'b1;
        end
      end
      ST_L1_REQ: if (xfer) state_n = ST_L1_DONE;
      ST_L1_DONE: begin
        // Always pass through FRM_END so the completed frame is accounted.
        if (PKT_DONE) begin
          state_n = ST_FRM_END;
        end else if (tmo_hit) begin
          state_n = ST_IDLE;
          clr_idx = 1'b1;
        end
      end
      ST_FRM_END: begin
        if (!START) begin
          state_n = ST_IDLE;
          clr_idx = 1'b1;
        end else begin
          state_n = ST_FRM_BEGIN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_idx  <= '0;
      sf_idx     <= '0;
      bb_idx     <= '0;
      lat_blocks <= '0;
      lat_frames <= '0;
      err_tmo    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q <= START;
      if (start_rise) begin
        err_tmo <= 1'b0;
      end else if (tmo_hit) begin
        err_tmo <= 1'b1;
      end
      if (clr_idx) begin
        frame_idx <= '0;
        sf_idx    <= '0;
        bb_idx    <= '0;
      end else begin
        case (state)
          ST_FRM_BEGIN: begin
            bb_idx <= '0;
            if (frame_idx == '0) begin
              lat_blocks <= plp_num_blocks;
              lat_frames <= num_t2_frames;
            end
          end
          ST_BB_DONE: if (PKT_DONE) bb_idx <= bb_idx + NB_ONE;
          ST_FRM_END: begin
            if (last_frm) begin
              frame_idx <= '0;
              sf_idx    <= sf_idx + SF_ONE;
            end else begin
              frame_idx <= frame_idx + NF_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef T2MI_SCHED_STATS_EN
  logic [31:0] stat_bb_q, stat_frm_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_bb_q  <= 32'd0;
      stat_frm_q <= 32'd0;
    end else begin
      if (xfer && (state == ST_BB_REQ)) stat_bb_q <= stat_bb_q + 32'd1;
      if (state == ST_FRM_END) stat_frm_q <= stat_frm_q + 32'd1;
    end
  end

  assign STAT_BB_CNT  = stat_bb_q;
  assign STAT_FRM_CNT = stat_frm_q;
`else
  assign STAT_BB_CNT  = 32'd0;
  assign STAT_FRM_CNT = 32'd0;
`endif

  assign REQ_VALID   = req_valid;
  assign REQ_TYPE    = state_pkt_type(state);
  assign FRAME_IDX   = frame_idx;
  assign SF_IDX      = sf_idx;
  assign BB_IDX      = bb_idx;
  assign FRAME_START = (state == ST_FRM_BEGIN);
  assign ERR_TMO     = err_tmo;
  assign fsm_state   = state;

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Testbench for t2mi_frame_scheduler. The bench plays the packet builder:
// it accepts each request after a random delay, answers with PKT_DONE after a
// random delay, and checks every transfer against a queue of expected
// (type, frame, superframe, block) tuples built from the frame/superframe
// schedule. Statistics checks follow T2MI_SCHED_STATS_EN.
module tb_t2mi_frame_scheduler;
  import t2mi_frame_scheduler_pkg::*;

  localparam int EW = 30;  // {type[8], frame[8], sf[4], bb[10]}

  logic        CLK = 1'b0;
  logic        RST, START, ENA, BB_AVAIL, REQ_READY, PKT_DONE;
  logic [9:0]  plp_num_blocks;
  logic [7:0]  num_t2_frames;
  logic        REQ_VALID, FRAME_START, ERR_TMO;
  logic [7:0]  REQ_TYPE;
  logic [7:0]  FRAME_IDX;
  logic [3:0]  SF_IDX;
  logic [9:0]  BB_IDX;
  logic [31:0] STAT_BB_CNT, STAT_FRM_CNT;
  state_e      fsm_state;

  int total = 0;
  int bad   = 0;
  int fs_cnt = 0;
  int exp_bb = 0;
  int exp_frm = 0;
  bit rand_avail = 1'b0;
  logic [EW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  t2mi_frame_scheduler #(.NB_W(10), .NF_W(8), .SF_W(4), .DONE_TMO(64)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ENA(ENA), .BB_AVAIL(BB_AVAIL),
    .plp_num_blocks(plp_num_blocks), .num_t2_frames(num_t2_frames),
    .REQ_VALID(REQ_VALID), .REQ_TYPE(REQ_TYPE), .REQ_READY(REQ_READY),
    .PKT_DONE(PKT_DONE), .FRAME_IDX(FRAME_IDX), .SF_IDX(SF_IDX), .BB_IDX(BB_IDX),
    .FRAME_START(FRAME_START), .ERR_TMO(ERR_TMO), .STAT_BB_CNT(STAT_BB_CNT),
    .STAT_FRM_CNT(STAT_FRM_CNT), .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [7:0] t, input int f, input int sf, input int b);
    return {t, 8'(f), 4'(sf % 16), 10'(b)};
  endfunction

  // Expected request order for one superframe: per frame, all BB blocks, then TS, then L1.
  // BB_IDX has counted past every block by the time TS/L1 are requested.
  function automatic void push_sf(input int blocks, input int frames, input int sf);
    int nf;
    nf = (frames == 0) ? 1 : frames;
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < blocks; b++) exp_q.push_back(mk(8'h00, f, sf, b));
      exp_q.push_back(mk(8'h20, f, sf, blocks));
      exp_q.push_back(mk(8'h10, f, sf, blocks));
    end
  endfunction

  task automatic tick();
    @(negedge CLK);
    if (FRAME_START === 1'b1) fs_cnt++;
    if (rand_avail) BB_AVAIL = ($urandom_range(0, 3) != 0);
  endtask

  // Accept one request after rdy_dly cycles, then (optionally) finish it done_dly cycles later.
  task automatic serve_one(input int rdy_dly, input int done_dly, input bit do_done);
    int t;
    bit stable;
    logic [EW-1:0] got, exp;
    t = 0;
    while (REQ_VALID !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    chk("req_wait", REQ_VALID, 1'b1);
    got = {REQ_TYPE, FRAME_IDX, SF_IDX, BB_IDX};
    stable = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      if ({REQ_VALID, REQ_TYPE, FRAME_IDX, SF_IDX, BB_IDX} !== {1'b1, got}) stable = 1'b0;
    end
    chk("req_stable", stable, 1'b1);
    REQ_READY = 1'b1;
    tick();
    REQ_READY = 1'b0;
    chk("valid_drop", REQ_VALID, 1'b0);
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL seq_extra observed=%0h expected=none", got);
    end
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("seq", got, exp);
      if (exp[EW-1 -: 8] == 8'h00) exp_bb++;
      if (do_done) begin
        repeat (done_dly) tick();
        PKT_DONE = 1'b1;
        tick();
        PKT_DONE = 1'b0;
        if (exp[EW-1 -: 8] == 8'h10) exp_frm++;
      end
    end
  endtask

  task automatic serve_n(input int n);
    for (int i = 0; i < n; i++) serve_one($urandom_range(0, 3), $urandom_range(1, 12), 1'b1);
  endtask

  task automatic stop_run(input string tag);
    START = 1'b0;
    tick();
    tick();
    chk({tag, "_idle"}, fsm_state, ST_IDLE);
    chk({tag, "_frame0"}, FRAME_IDX, 0);
    chk({tag, "_sf0"}, SF_IDX, 0);
    exp_q.delete();
  endtask

  task automatic chk_stats(input string tag);
`ifdef T2MI_SCHED_STATS_EN
    chk({tag, "_stat_bb"}, STAT_BB_CNT, exp_bb);
    chk({tag, "_stat_frm"}, STAT_FRM_CNT, exp_frm);
`else
    chk({tag, "_stat_bb"}, STAT_BB_CNT, 0);
    chk({tag, "_stat_frm"}, STAT_FRM_CNT, 0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, REQ_VALID, 0);
    chk({tag, "_type"}, REQ_TYPE, 0);
    chk({tag, "_frame"}, FRAME_IDX, 0);
    chk({tag, "_sf"}, SF_IDX, 0);
    chk({tag, "_bb"}, BB_IDX, 0);
    chk({tag, "_fstart"}, FRAME_START, 0);
    chk({tag, "_err"}, ERR_TMO, 0);
    chk({tag, "_state"}, fsm_state, ST_IDLE);
    chk({tag, "_stat_bb"}, STAT_BB_CNT, 0);
    chk({tag, "_stat_frm"}, STAT_FRM_CNT, 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; ENA = 1'b1; BB_AVAIL = 1'b0; REQ_READY = 1'b0;
    PKT_DONE = 1'b0; plp_num_blocks = 10'd0; num_t2_frames = 8'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    tick();
    chk_all_zero("reset");

    // 1: blocks=2, frames=2, READY immediate, DONE 10 cycles after each transfer.
    plp_num_blocks = 10'd2; num_t2_frames = 8'd2;
    push_sf(2, 2, 0);
    START = 1'b1;
    tick();
    chk("t1_start_latency", FRAME_START, 1'b1);
    tick();
    tick();
    chk("t1_no_avail", REQ_VALID, 1'b0);
    PKT_DONE = 1'b1;
    tick();
    PKT_DONE = 1'b0;
    chk("t1_stray_done_bb", BB_IDX, 0);
    chk("t1_stray_done_valid", REQ_VALID, 1'b0);
    BB_AVAIL = 1'b1;
    tick();
    chk("t1_avail_latency", REQ_VALID, 1'b1);
    for (int i = 0; i < 8; i++) serve_one(0, 10, 1'b1);
    tick();
    chk("t1_sf_wrap_sf", SF_IDX, 1);
    chk("t1_sf_wrap_frame", FRAME_IDX, 0);
    chk("t1_sf_wrap_fstart", FRAME_START, 1'b1);
    stop_run("t1");
    chk_stats("t1");

    // 2: blocks=0, frames=1 -> TS, L1 per frame; 17 frames exercise SF_IDX wrap.
    rand_avail = 1'b1;
    plp_num_blocks = 10'd0; num_t2_frames = 8'd1;
    for (int s = 0; s < 17; s++) push_sf(0, 1, s);
    fs_cnt = 0;
    START = 1'b1;
    serve_n(34);
    chk("t2_no_leftover", exp_q.size(), 0);
    stop_run("t2");
    chk("t2_frame_starts", fs_cnt, 17);
    chk_stats("t2");

    // 3: request held unaccepted for 50 cycles; ENA low withdraws REQ_VALID only.
    push_sf(0, 1, 0);
    START = 1'b1;
    for (int t = 0; t < 50 && REQ_VALID !== 1'b1; t++) tick();
    ENA = 1'b0;
    #1;
    chk("t3_ena_low_valid", REQ_VALID, 1'b0);
    chk("t3_ena_low_type", REQ_TYPE, 8'h20);
    ENA = 1'b1;
    #1;
    chk("t3_ena_back_valid", REQ_VALID, 1'b1);
    serve_one(50, 5, 1'b1);
    chk("t3_no_tmo", ERR_TMO, 1'b0);
    serve_one(2, 5, 1'b1);
    stop_run("t3");

    // 4: PKT_DONE withheld -> timeout after DONE_TMO=64 cycles in DONE.
    plp_num_blocks = 10'd1; num_t2_frames = 8'd1;
    push_sf(1, 1, 0);
    START = 1'b1;
    serve_one(0, 0, 1'b0);
    repeat (63) tick();
    chk("t4_before_tmo_err", ERR_TMO, 1'b0);
    chk("t4_before_tmo_state", fsm_state, ST_BB_DONE);
    tick();
    chk("t4_tmo_err", ERR_TMO, 1'b1);
    chk("t4_tmo_state", fsm_state, ST_IDLE);
    chk("t4_tmo_valid", REQ_VALID, 1'b0);
    chk("t4_tmo_frame", FRAME_IDX, 0);
    fs_cnt = 0;
    repeat (5) tick();
    chk("t4_hold_idle", fsm_state, ST_IDLE);
    chk("t4_hold_fstart", fs_cnt, 0);
    chk("t4_hold_err", ERR_TMO, 1'b1);
    START = 1'b0;
    repeat (3) tick();
    START = 1'b1;
    tick();
    chk("t4_restart_err", ERR_TMO, 1'b0);
    chk("t4_restart_fstart", FRAME_START, 1'b1);
    chk("t4_restart_frame", FRAME_IDX, 0);
    exp_q.delete();
    push_sf(1, 1, 0);
    serve_n(3);
    stop_run("t4");
    chk_stats("t4");

    // 5: plp_num_blocks 3->5 during superframe 0 (frames=4), then RST in BB_DONE.
    plp_num_blocks = 10'd3; num_t2_frames = 8'd4;
    push_sf(3, 4, 0);
    push_sf(5, 4, 1);
    START = 1'b1;
    serve_n(5);
    plp_num_blocks = 10'd5;
    serve_n(15 + 28);
    push_sf(5, 4, 2);
    serve_one(1, 0, 1'b0);
    chk("t5_in_bb_done", fsm_state, ST_BB_DONE);
    chk("t5_sf_before_rst", SF_IDX, 2);
    chk_stats("t5");
    RST = 1'b1;
    START = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    exp_q.delete();
    exp_bb = 0;
    exp_frm = 0;
    tick();
    RST = 1'b0;
    tick();

    // 6: 10 frames of 3 blocks from reset -> statistics.
    plp_num_blocks = 10'd3; num_t2_frames = 8'd10;
    push_sf(3, 10, 0);
    START = 1'b1;
    serve_n(50);
    stop_run("t6");
    chk_stats("t6");
`ifdef T2MI_SCHED_STATS_EN
    chk("t6_bb_30", STAT_BB_CNT, 30);
    chk("t6_frm_10", STAT_FRM_CNT, 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
